// File: rtl/apb_slave_regfile_if.sv
// APB3/APB4 bus bundle between a requester and the register-file completer.
// Completer outputs keep the o_ prefix used throughout the sandbox.
interface apb_slave_regfile_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic [ADDR_W-1:0]   paddr;
  logic [DATA_W-1:0]   pwdata;
  logic [DATA_W/8-1:0] pstrb;
  logic                pwrite;
  logic                psel;
  logic                pen;
  logic [DATA_W-1:0]   o_prdata;
  logic                o_pready;
  logic                o_pslverr;

  modport master (
    output paddr, pwdata, pstrb,
    output pwrite, psel, pen,
    input  o_prdata, o_pready, o_pslverr
  );

  modport slave (
    input  paddr, pwdata, pstrb,
    input  pwrite, psel, pen,
    output o_prdata, o_pready, o_pslverr
  );
endinterface

// File: rtl/apb_slave_regfile.sv
// APB completer backed by a DEPTH-word register file with
// programmable wait states, byte strobes and PSLVERR on bad addresses.
module apb_slave_regfile #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int DEPTH       = 32,
  parameter int WAIT_STATES = 0
) (
  input logic                pclk,
  input logic                prst_n,
  apb_slave_regfile_if.slave bus
);

  localparam int NB = DATA_W / 8;
  localparam int B  = $clog2(NB);
  localparam int IW = $clog2(DEPTH);

  localparam logic [ADDR_W-1:0] AMASK =
    ADDR_W'((1 << B) - 1);
  localparam logic [ADDR_W-1:0] ADEPTH =
    ADDR_W'(DEPTH);
  localparam logic [3:0] WS = 4'(WAIT_STATES);

  typedef enum logic {
    IDLE,
    ACCESS
  } state_t;

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              rdy_q, rdy_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              load;
  logic              commit;

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [ADDR_W-1:0] idx_full;
  logic [IW-1:0]     idx;
  logic              bad;

  assign idx_full = bus.paddr >> B;
  assign idx      = idx_full[IW-1:0];
  assign bad      = (|(bus.paddr & AMASK)) ||
                    (idx_full >= ADEPTH);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdy_d   = rdy_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    load    = 1'b0;
    commit  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.psel && !bus.pen) begin
          state_d = ACCESS;
          cnt_d   = WS;
          if (WS == 4'd0) begin
            rdy_d = 1'b1;
            load  = 1'b1;
          end
        end
      end
      ACCESS: begin
        // completion takes priority over a late psel drop
        if (rdy_q) begin
          commit  = bus.pwrite && !err_q;
          rdy_d   = 1'b0;
          err_d   = 1'b0;
          state_d = IDLE;
        end else if (!bus.psel) begin
          state_d = IDLE;
          cnt_d   = 4'd0;
          rdy_d   = 1'b0;
        end else if (cnt_q > 4'd1) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          cnt_d = 4'd0;
          rdy_d = 1'b1;
          load  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (load) begin
      err_d = bad;
      if (!bus.pwrite) begin
        rdata_d = bad ? '0 : mem_q[idx];
      end
    end
  end

  always_ff @(posedge pclk or negedge prst_n) begin
    if (!prst_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      rdy_q   <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdy_q   <= rdy_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  always_ff @(posedge pclk or negedge prst_n) begin
    if (!prst_n) begin
      for (int w = 0; w < DEPTH; w++) begin
        mem_q[w] <= '0;
      end
    end else if (commit) begin
      for (int i = 0; i < NB; i++) begin
        if (bus.pstrb[i]) begin
          mem_q[idx][8*i +: 8] <= bus.pwdata[8*i +: 8];
        end
      end
    end
  end

  assign bus.o_prdata  = rdata_q;
  assign bus.o_pready  = rdy_q;
  assign bus.o_pslverr = err_q;

endmodule

// File: tb/tb_apb_slave_regfile.sv
// Directed bench: WAIT_STATES=0 and WAIT_STATES=3 completers
// on a shared clock, reset and request bus.
module tb_apb_slave_regfile;

  logic        pclk;
  logic        prst_n;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic        pwrite;
  logic        pen;
  logic        psel0;
  logic        psel3;

  int total = 0;
  int bad   = 0;
  int rc0   = 0;
  int rc3   = 0;

  apb_slave_regfile_if #(.DATA_W(32), .ADDR_W(32)) if0 ();
  apb_slave_regfile_if #(.DATA_W(32), .ADDR_W(32)) if3 ();

  assign if0.paddr  = paddr;
  assign if0.pwdata = pwdata;
  assign if0.pstrb  = pstrb;
  assign if0.pwrite = pwrite;
  assign if0.pen    = pen;
  assign if0.psel   = psel0;
  assign if3.paddr  = paddr;
  assign if3.pwdata = pwdata;
  assign if3.pstrb  = pstrb;
  assign if3.pwrite = pwrite;
  assign if3.pen    = pen;
  assign if3.psel   = psel3;

  apb_slave_regfile #(
    .DATA_W(32), .ADDR_W(32),
    .DEPTH(32), .WAIT_STATES(0)
  ) u0 (
    .pclk(pclk), .prst_n(prst_n), .bus(if0.slave)
  );

  apb_slave_regfile #(
    .DATA_W(32), .ADDR_W(32),
    .DEPTH(32), .WAIT_STATES(3)
  ) u3 (
    .pclk(pclk), .prst_n(prst_n), .bus(if3.slave)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  always @(negedge pclk) begin
    if (if0.o_pready === 1'b1) rc0++;
    if (if3.o_pready === 1'b1) rc3++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: sim time expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h",
               nm, act, exp);
    end
  endtask

  // lat = access cycle in which o_pready was seen, 0 on timeout
  task automatic xfer(input int d, input bit wr,
                      input logic [31:0] a,
                      input logic [31:0] wd,
                      input logic [3:0] s,
                      output logic [31:0] rd,
                      output logic er,
                      output int lat);
    logic r;
    @(posedge pclk); #1;
    psel0  = (d == 0);
    psel3  = (d != 0);
    pen    = 1'b0;
    pwrite = wr;
    paddr  = a;
    pwdata = wd;
    pstrb  = s;
    @(posedge pclk); #1;
    pen = 1'b1;
    lat = 0;
    for (int n = 1; n <= 40; n++) begin
      r = (d == 0) ? if0.o_pready : if3.o_pready;
      if (r === 1'b1) begin
        lat = n;
        break;
      end
      @(posedge pclk); #1;
    end
    rd = (d == 0) ? if0.o_prdata : if3.o_prdata;
    er = (d == 0) ? if0.o_pslverr : if3.o_pslverr;
  endtask

  task automatic idle();
    @(posedge pclk); #1;
    psel0 = 1'b0;
    psel3 = 1'b0;
    pen   = 1'b0;
  endtask

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    bit          chk_d;
    logic [31:0] exp_d;
    bit          exp_e;
  } vec_t;

  vec_t        vt[12];
  logic [31:0] rd;
  logic        er;
  int          lat;
  int          base;

  initial begin
    vt[0]  = '{1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 1'b1, 32'h0, 1'b0};
    vt[1]  = '{1'b0, 32'h10, 32'h0, 4'h0, 1'b1, 32'hDEADBEEF, 1'b0};
    vt[2]  = '{1'b1, 32'h08, 32'h11223344, 4'hF, 1'b1, 32'hDEADBEEF, 1'b0};
    vt[3]  = '{1'b1, 32'h08, 32'hAABBCCDD, 4'h5, 1'b1, 32'hDEADBEEF, 1'b0};
    vt[4]  = '{1'b0, 32'h08, 32'h0, 4'h0, 1'b1, 32'h11BB33DD, 1'b0};
    vt[5]  = '{1'b0, 32'h80, 32'h0, 4'h0, 1'b1, 32'h0, 1'b1};
    vt[6]  = '{1'b1, 32'h06, 32'h12345678, 4'hF, 1'b0, 32'h0, 1'b1};
    vt[7]  = '{1'b0, 32'h04, 32'h0, 4'h0, 1'b1, 32'h0, 1'b0};
    vt[8]  = '{1'b1, 32'h7C, 32'hFFFF0000, 4'h0, 1'b1, 32'h0, 1'b0};
    vt[9]  = '{1'b0, 32'h7C, 32'h0, 4'h0, 1'b1, 32'h0, 1'b0};
    vt[10] = '{1'b1, 32'h7C, 32'hCAFEF00D, 4'hF, 1'b1, 32'h0, 1'b0};
    vt[11] = '{1'b0, 32'h7C, 32'h0, 4'h0, 1'b1, 32'hCAFEF00D, 1'b0};

    prst_n = 1'b0;
    psel0  = 1'b0;
    psel3  = 1'b0;
    pen    = 1'b0;
    pwrite = 1'b0;
    paddr  = '0;
    pwdata = '0;
    pstrb  = '0;
    repeat (3) @(posedge pclk);
    #1 prst_n = 1'b1;
    @(posedge pclk); #1;
    chk("rst_rdy0", {31'b0, if0.o_pready}, 32'h0);
    chk("rst_err0", {31'b0, if0.o_pslverr}, 32'h0);
    chk("rst_data0", if0.o_prdata, 32'h0);

    // WAIT_STATES=0 table, issued back to back
    base = rc0;
    for (int i = 0; i < 12; i++) begin
      xfer(0, vt[i].wr, vt[i].addr, vt[i].wdata,
           vt[i].strb, rd, er, lat);
      chk($sformatf("v%0d_lat", i), lat, 32'd1);
      chk($sformatf("v%0d_err", i), {31'b0, er},
          {31'b0, vt[i].exp_e});
      if (vt[i].chk_d)
        chk($sformatf("v%0d_data", i), rd, vt[i].exp_d);
    end
    idle();
    chk("ws0_rdy_count", rc0 - base, 32'd12);

    // WAIT_STATES=3 read latency and single-cycle pready
    idle();
    base = rc3;
    xfer(3, 1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat);
    chk("ws3_rd_lat", lat, 32'd4);
    chk("ws3_rd_data", rd, 32'h0);
    chk("ws3_rd_err", {31'b0, er}, 32'h0);
    idle();
    @(posedge pclk); #1;
    chk("ws3_rdy_once", rc3 - base, 32'd1);

    // abort mid-ACCESS on a write
    xfer(3, 1'b1, 32'h20, 32'h00001234, 4'hF, rd, er, lat);
    chk("ws3_pre_lat", lat, 32'd4);
    idle();
    base = rc3;
    @(posedge pclk); #1;
    psel3  = 1'b1;
    pen    = 1'b0;
    pwrite = 1'b1;
    paddr  = 32'h20;
    pwdata = 32'h00009999;
    pstrb  = 4'hF;
    @(posedge pclk); #1;
    pen = 1'b1;
    repeat (2) @(posedge pclk);
    #1;
    psel3 = 1'b0;
    pen   = 1'b0;
    repeat (6) @(posedge pclk);
    #1;
    chk("abort_no_rdy", rc3 - base, 32'd0);
    xfer(3, 1'b0, 32'h20, 32'h0, 4'h0, rd, er, lat);
    chk("abort_word", rd, 32'h00001234);
    idle();

    // back-to-back: four writes then four reads
    base = rc3;
    for (int i = 0; i < 4; i++) begin
      xfer(3, 1'b1, 32'(4 * i), 32'hA0B0C000 + 32'(i),
           4'hF, rd, er, lat);
      chk($sformatf("b2b_wlat%0d", i), lat, 32'd4);
    end
    for (int i = 0; i < 4; i++) begin
      xfer(3, 1'b0, 32'(4 * i), 32'h0, 4'h0, rd, er, lat);
      chk($sformatf("b2b_rd%0d", i), rd,
          32'hA0B0C000 + 32'(i));
    end
    idle();
    chk("b2b_rdy_count", rc3 - base, 32'd8);

    // reset in the middle of a write to idx 5
    xfer(3, 1'b1, 32'h14, 32'hA5A5A5A5, 4'hF, rd, er, lat);
    xfer(3, 1'b0, 32'h14, 32'h0, 4'h0, rd, er, lat);
    chk("pre_rst_rd", rd, 32'hA5A5A5A5);
    xfer(3, 1'b1, 32'h14, 32'h5A5A5A5A, 4'hF, rd, er, lat);
    idle();
    @(posedge pclk); #1;
    psel3  = 1'b1;
    pen    = 1'b0;
    pwrite = 1'b1;
    paddr  = 32'h14;
    pwdata = 32'h12121212;
    @(posedge pclk); #1;
    pen = 1'b1;
    @(posedge pclk); #1;
    prst_n = 1'b0;
    #1;
    chk("arst_data", if3.o_prdata, 32'h0);
    repeat (2) @(posedge pclk);
    #1;
    psel3  = 1'b0;
    pen    = 1'b0;
    prst_n = 1'b1;
    @(posedge pclk); #1;
    chk("rst_rdy3", {31'b0, if3.o_pready}, 32'h0);
    chk("rst_err3", {31'b0, if3.o_pslverr}, 32'h0);
    chk("rst_data3", if3.o_prdata, 32'h0);
    xfer(3, 1'b0, 32'h14, 32'h0, 4'h0, rd, er, lat);
    chk("rst_idx5", rd, 32'h0);
    xfer(0, 1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat);
    chk("rst_ws0_mem", rd, 32'h0);
    idle();

    repeat (2) @(posedge pclk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
